// File: rtl/serial_addsub_ctrl.sv
// Bit-serial WIDTH-bit add/subtract sequencer: operands are walked LSB-first
// through one 1-bit add/sub cell, with a carry/borrow flop held between bits.

module addsub_cell (
  input  logic sub,
  input  logic ai,
  input  logic bi,
  input  logic ci,
  output logic s,
  output logic co
);
  logic s1, g1, g2;

  // Two cascaded half stages; the subtract variant inverts the minuend term.
  always_comb begin
    s1 = ai ^ bi;
    g1 = sub ? (~ai & bi) : (ai & bi);
    s  = s1 ^ ci;
    g2 = sub ? (~s1 & ci) : (s1 & ci);
    co = g1 | g2;
  end
endmodule

module serial_addsub_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state, state_next;
  logic [WIDTH-1:0] a_sh, b_sh, res_sh;
  logic             op_q;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic             last_bit;
  logic             cell_s, cell_c;

  addsub_cell u_cell (
    .sub (op_q),
    .ai  (a_sh[0]),
    .bi  (b_sh[0]),
    .ci  (carry),
    .s   (cell_s),
    .co  (cell_c)
  );

  assign last_bit = (cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: start only takes effect in IDLE, so a busy request is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      op_q   <= 1'b0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a;
            b_sh  <= b;
            op_q  <= op;
            carry <= 1'b0;
            cnt   <= '0;
          end
        end
        RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= {cell_s, res_sh[WIDTH-1:1]};
          carry  <= cell_c;
          cnt    <= cnt + CW'(1);
        end
        default: ;
      endcase
    end
  end

  assign result = res_sh;
  assign cout   = carry;
endmodule

// File: tb/tb_serial_addsub_ctrl.sv
// Scoreboard bench for serial_addsub_ctrl: a WIDTH=4 instance for timing and
// handshake scenarios, a WIDTH=8 instance for edge values and a random sweep.

module tb_serial_addsub_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n4, start4, op4, busy4, done4, cout4;
  logic [3:0] a4, b4, result4;
  logic       rst_n8, start8, op8, busy8, done8, cout8;
  logic [7:0] a8, b8, result8;

  int checks   = 0;
  int failures = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];
  logic [4:0] e4;
  logic [8:0] e8;
  logic       done4_prev = 1'b0;
  logic       done8_prev = 1'b0;

  serial_addsub_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst_n(rst_n4), .start(start4), .op(op4), .a(a4), .b(b4),
    .busy(busy4), .done(done4), .result(result4), .cout(cout4)
  );

  serial_addsub_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst_n(rst_n8), .start(start8), .op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(result8), .cout(cout8)
  );

  // Scoreboard monitor: pop and compare on every done pulse
  always @(negedge clk) begin
    if (done4) begin
      checks++;
      if (q4.size() == 0) begin
        failures++;
        $display("FAIL sb4_unexpected_done got result=%h cout=%b required no done", result4, cout4);
      end else begin
        e4 = q4.pop_front();
        $display("dut4 txn result=%h cout=%b expected result=%h cout=%b", result4, cout4, e4[3:0], e4[4]);
        if ({cout4, result4} !== e4) begin
          failures++;
          $display("FAIL sb4_result got cout=%b result=%h required cout=%b result=%h",
                   cout4, result4, e4[4], e4[3:0]);
        end
      end
      checks++;
      if (done4_prev !== 1'b0) begin
        failures++;
        $display("FAIL done4_pulse got done high 2 cycles required single-cycle pulse");
      end
    end
    if (done8) begin
      checks++;
      if (q8.size() == 0) begin
        failures++;
        $display("FAIL sb8_unexpected_done got result=%h cout=%b required no done", result8, cout8);
      end else begin
        e8 = q8.pop_front();
        $display("dut8 txn result=%h cout=%b expected result=%h cout=%b", result8, cout8, e8[7:0], e8[8]);
        if ({cout8, result8} !== e8) begin
          failures++;
          $display("FAIL sb8_result got cout=%b result=%h required cout=%b result=%h",
                   cout8, result8, e8[8], e8[7:0]);
        end
      end
      checks++;
      if (done8_prev !== 1'b0) begin
        failures++;
        $display("FAIL done8_pulse got done high 2 cycles required single-cycle pulse");
      end
    end
    done4_prev = done4;
    done8_prev = done8;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic do_op4(input logic o, input logic [3:0] x, input logic [3:0] y);
    logic [3:0] d;
    int n;
    @(negedge clk);
    op4 = o; a4 = x; b4 = y; start4 = 1'b1;
    d = x - y;
    if (o) q4.push_back({(x < y), d});
    else   q4.push_back({1'b0, x} + {1'b0, y});
    @(negedge clk);
    start4 = 1'b0; a4 = 4'($urandom); b4 = 4'($urandom); op4 = 1'($urandom);
    n = 0;
    while (busy4 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $display("FAIL op4_timeout got busy=%b required 0 within 20 cycles", busy4);
    end
  endtask

  task automatic do_op8(input logic o, input logic [7:0] x, input logic [7:0] y);
    logic [7:0] d;
    int n;
    @(negedge clk);
    op8 = o; a8 = x; b8 = y; start8 = 1'b1;
    d = x - y;
    if (o) q8.push_back({(x < y), d});
    else   q8.push_back({1'b0, x} + {1'b0, y});
    @(negedge clk);
    start8 = 1'b0; a8 = 8'($urandom); b8 = 8'($urandom); op8 = 1'($urandom);
    n = 0;
    while (busy8 && n < 30) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (busy8 !== 1'b0) begin
      failures++;
      $display("FAIL op8_timeout got busy=%b required 0 within 30 cycles", busy8);
    end
  endtask

  task automatic test_reset();
    rst_n4 = 1'b0; start4 = 1'b0; op4 = 1'b0; a4 = '0; b4 = '0;
    rst_n8 = 1'b0; start8 = 1'b0; op8 = 1'b0; a8 = '0; b8 = '0;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy4, done4, cout4, result4} !== 7'd0) begin
      failures++;
      $display("FAIL reset4 got busy=%b done=%b cout=%b result=%h required all 0",
               busy4, done4, cout4, result4);
    end
    checks++;
    if ({busy8, done8, cout8, result8} !== 11'd0) begin
      failures++;
      $display("FAIL reset8 got busy=%b done=%b cout=%b result=%h required all 0",
               busy8, done8, cout8, result8);
    end
    rst_n4 = 1'b1;
    rst_n8 = 1'b1;
  endtask

  task automatic test_basic_add();
    @(negedge clk);
    op4 = 1'b0; a4 = 4'b1011; b4 = 4'b0110; start4 = 1'b1;
    q4.push_back(5'b1_0001);
    @(negedge clk);
    start4 = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      if (i > 1) @(negedge clk);
      checks++;
      if (busy4 !== (i <= 5)) begin
        failures++;
        $display("FAIL basic_busy cycle %0d got busy=%b required %b", i, busy4, (i <= 5));
      end
      checks++;
      if (done4 !== (i == 5)) begin
        failures++;
        $display("FAIL basic_done cycle %0d got done=%b required %b", i, done4, (i == 5));
      end
    end
  endtask

  task automatic test_sub();
    do_op4(1'b1, 4'd9, 4'd5);
    do_op4(1'b1, 4'd5, 4'd9);
  endtask

  task automatic test_start_held();
    int dcount;
    dcount = 0;
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      if (done4) begin
        dcount++;
        checks++;
        if (i != 5 + 6 * (dcount - 1)) begin
          failures++;
          $display("FAIL held_spacing got done at cycle %0d required %0d", i, 5 + 6 * (dcount - 1));
        end
      end
      if (!busy4) begin
        q4.push_back(5'd7);
        start4 = 1'b1;
      end
      if (!busy4 || done4) begin
        op4 = 1'b0; a4 = 4'd3; b4 = 4'd4;
      end else begin
        op4 = 1'($urandom); a4 = 4'($urandom); b4 = 4'($urandom);
      end
    end
    start4 = 1'b0;
    checks++;
    if (dcount != 3) begin
      failures++;
      $display("FAIL held_count got %0d done pulses required 3", dcount);
    end
    @(negedge clk);
  endtask

  task automatic test_busy_ignore();
    @(negedge clk);
    op4 = 1'b0; a4 = 4'd2; b4 = 4'd3; start4 = 1'b1;
    q4.push_back(5'd5);
    @(negedge clk);
    start4 = 1'b0;
    repeat (3) begin
      @(negedge clk);
      start4 = 1'b1; op4 = 1'b1; a4 = 4'd15; b4 = 4'd1;
    end
    @(negedge clk);
    start4 = 1'b0;
    checks++;
    if (done4 !== 1'b1) begin
      failures++;
      $display("FAIL ignore_done got done=%b required 1", done4);
    end
    repeat (2) begin
      @(negedge clk);
      checks++;
      if (busy4 !== 1'b0) begin
        failures++;
        $display("FAIL ignore_busy got busy=%b required 0", busy4);
      end
    end
  endtask

  task automatic test_reset_mid_run();
    @(negedge clk);
    op4 = 1'b0; a4 = 4'd1; b4 = 4'd1; start4 = 1'b1;
    @(negedge clk);
    start4 = 1'b0;
    @(negedge clk);
    rst_n4 = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy4, done4, cout4, result4} !== 7'd0) begin
      failures++;
      $display("FAIL midreset got busy=%b done=%b cout=%b result=%h required all 0",
               busy4, done4, cout4, result4);
    end
    rst_n4 = 1'b1;
    @(negedge clk);
    checks++;
    if (busy4 !== 1'b0) begin
      failures++;
      $display("FAIL midreset_idle got busy=%b required 0", busy4);
    end
    do_op4(1'b0, 4'd15, 4'd1);
  endtask

  task automatic test_edges8();
    do_op8(1'b0, 8'hFF, 8'hFF);
    do_op8(1'b1, 8'h00, 8'h01);
    do_op8(1'b1, 8'h00, 8'h00);
    do_op8(1'b0, 8'h00, 8'h00);
    do_op8(1'b1, 8'hA5, 8'hA5);
  endtask

  task automatic test_random8();
    for (int i = 0; i < 500; i++) begin
      do_op8(1'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_sub();
    test_start_held();
    test_busy_ignore();
    test_reset_mid_run();
    test_edges8();
    test_random8();
    repeat (3) @(negedge clk);
    checks++;
    if (q4.size() != 0) begin
      failures++;
      $display("FAIL sb4_drain got %0d pending required 0", q4.size());
    end
    checks++;
    if (q8.size() != 0) begin
      failures++;
      $display("FAIL sb8_drain got %0d pending required 0", q8.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/serial_addsub_ctrl.md
Name: serial_addsub_ctrl

Overview:
- Bit-serial N-bit add/subtract sequencer built around a single 1-bit add/sub cell.
- The cell is composed of two cascaded half-adder stages (add) or half-subtractor stages (sub), plus an OR for carry/borrow merge.
- The controller captures two operands, walks them LSB-first through the cell one bit per clock, and holds a carry/borrow flop between bits.
- Sits between a requester issuing start/op and downstream logic consuming result/cout on a done pulse.

Parameters:
- WIDTH, 8, operand/result width in bits (legal range 2..32).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- start  input  1  request; sampled only in IDLE
- op  input  1  0 = add (a+b), 1 = subtract (a-b); captured with start
- a  input  WIDTH  operand A; captured with start
- b  input  WIDTH  operand B; captured with start
- busy  output  1  high in RUN and DONE
- done  output  1  one-cycle pulse when result/cout are valid
- result  output  WIDTH  sum or difference, held until next accepted start
- cout  output  1  carry-out (add) or borrow-out (sub), held with result

Behaviour:
- Reset: rst_n low at a rising edge forces the following, regardless of state, including mid-operation:
  - state = IDLE
  - busy = 0, done = 0, result = 0, cout = 0
  - internal operand shift registers, bit counter and carry/borrow flop = 0
- States and transitions:
  - IDLE: start = 1 at an edge → load A/B shift registers, latch op, clear carry/borrow flop, clear counter, go to RUN. start = 0 → stay.
  - RUN: each edge processes bit index = counter.
    - A/B shift right by one; the cell output shifts into result MSB (result shifts right).
    - The carry/borrow flop takes the cell's carry/borrow out.
    - Counter increments.
    - When the counter reaches WIDTH-1 on this edge (last bit processed), go to DONE.
  - DONE: done = 1 for exactly this cycle. cout = carry/borrow flop, result final. Next edge → IDLE unconditionally.
- Bit cell (combinational; ai, bi = current LSBs, c = flop):
  - add: s = ai^bi^c; c' = (ai&bi) | (c&(ai^bi)).
  - sub: d = ai^bi^c; c' = (~ai&bi) | (c&~(ai^bi)).
- Latency: start sampled at edge k → RUN for edges k+1..k+WIDTH → done high during the cycle after edge k+WIDTH, then IDLE after edge k+WIDTH+1.
  - Next start is accepted at edge k+WIDTH+2 at the earliest.
- Handshake:
  - start while busy = 1 (RUN or DONE) is ignored, with no queuing.
  - a/b/op may change freely after capture.
- Arithmetic: modulo 2^WIDTH.
  - add: cout = 1 iff a+b ≥ 2^WIDTH.
  - sub: result = (a-b) mod 2^WIDTH; cout (borrow) = 1 iff a < b unsigned.
- Output holding:
  - result and cout are updated only as specified above and are stable from done until the next accepted start.
  - During RUN, result holds partial shift contents and is not valid.
- Boundary values: a = b = 0 → result 0, cout 0. Equal operands under sub → result 0, borrow 0. All-ones + all-ones → result all-ones minus 1, cout 1.

Test Plan:
- WIDTH=4, add, a=4'b1011, b=4'b0110, start pulse → busy for 5 cycles; done 5 cycles after the start edge; result=4'b0001, cout=1.
- WIDTH=4, sub, a=4'd9, b=4'd5 → result=4'd4, cout=0. Then sub a=4'd5, b=4'd9 → result=4'b1100, cout=1.
- start held high continuously, add 3+4 → exactly one operation per WIDTH+2 cycles. Operand change mid-RUN has no effect; result=7 each time.
- Reset asserted on the 2nd RUN cycle → next cycle busy=0, done=0, result=0, cout=0, state IDLE. A new start then completes correctly (add 15+1 → result 0, cout 1).
- WIDTH=8 random sweep (≥500 ops, both op values) compared against a reference model → result and cout match; done is always a single-cycle pulse.
- Edge values WIDTH=8: add 255+255 → 8'hFE, cout 1. Sub 0-1 → 8'hFF, borrow 1. Sub 0-0 → 0, borrow 0.
